// File: rtl/hack_pkg.sv
// Shared constants and helpers for the Hack data-memory map.
// Holds word and address widths, the address-map constants, the region type and
// the address decoder that the memory top uses.
package hack_pkg;

    localparam int unsigned WORD_W     = 16;
    localparam int unsigned ADDR_W     = 15;
    localparam int unsigned RAM_ADDR_W = 14;
    localparam int unsigned SCR_ADDR_W = 13;

    localparam int unsigned RAM_WORDS = 16384;
    localparam int unsigned SCR_WORDS = 8192;

    localparam logic [ADDR_W-1:0] RAM_BASE = 15'h0000;
    localparam logic [ADDR_W-1:0] SCR_BASE = 15'h4000;
    localparam logic [ADDR_W-1:0] KBD_ADDR = 15'h6000;

    typedef enum logic [1:0] {
        REG_RAM  = 2'd0,
        REG_SCR  = 2'd1,
        REG_KBD  = 2'd2,
        REG_NONE = 2'd3
    } region_e;

    // Map a CPU data address onto the region that owns it.
    function automatic region_e decode(input logic [ADDR_W-1:0] addr);
        region_e r;
        r = REG_NONE;
        if (addr < RAM_BASE + ADDR_W'(RAM_WORDS)) begin
            r = REG_RAM;
        end else if (addr >= SCR_BASE && addr < SCR_BASE + ADDR_W'(SCR_WORDS)) begin
            r = REG_SCR;
        end else if (addr == KBD_ADDR) begin
            r = REG_KBD;
        end
        return r;
    endfunction

endpackage

// File: rtl/key_fifo.sv
// Keyboard key-code FIFO.
// Ports: clk, reset (sync, active-low), push/din write side, pop/dout read side
// (dout is the current head, combinational), full, empty.
// Pushes while full and pops while empty are ignored; a push and pop in the same
// cycle on a non-empty FIFO keeps the count unchanged.
module key_fifo
    import hack_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [WORD_W-1:0] din,
    output logic [WORD_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rptr;
    logic [PTR_W-1:0]  wptr;
    logic [CNT_W-1:0]  count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr];

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (reset && do_push) begin
            mem[wptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (do_pop) begin
                rptr <= rptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/hack_memory.sv
// Hack computer data memory: 16K RAM, 8K screen, keyboard register backed by a FIFO.
// Ports: clk, reset (sync, active-low); CPU side address/in_data/load with
// combinational out_data; keyboard side kbd_valid/kbd_code/kbd_ready;
// display scanner side scr_addr with registered scr_data.
module hack_memory
    import hack_pkg::*;
#(
    parameter int unsigned KBD_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     address,
    input  logic [WORD_W-1:0]     in_data,
    input  logic                  load,
    output logic [WORD_W-1:0]     out_data,
    input  logic                  kbd_valid,
    input  logic [WORD_W-1:0]     kbd_code,
    output logic                  kbd_ready,
    input  logic [SCR_ADDR_W-1:0] scr_addr,
    output logic [WORD_W-1:0]     scr_data
);

    logic [WORD_W-1:0] ram_mem [RAM_WORDS];
    logic [WORD_W-1:0] scr_mem [SCR_WORDS];

    region_e           region;
    logic              wr_en;
    logic              kbd_full;
    logic              kbd_empty;
    logic [WORD_W-1:0] kbd_head;
    logic              kbd_push;
    logic              kbd_pop;

    assign region = decode(address);
    assign wr_en  = reset && load;

    // Ready is forced low during reset and whenever full, even if a pop is pending.
    assign kbd_ready = reset && !kbd_full;
    assign kbd_push  = kbd_valid && kbd_ready;
    // A CPU write to the keyboard register is a pop; the write data is dropped.
    assign kbd_pop   = wr_en && (region == REG_KBD);

    key_fifo #(
        .DEPTH (KBD_DEPTH)
    ) u_key_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (kbd_push),
        .pop   (kbd_pop),
        .din   (kbd_code),
        .dout  (kbd_head),
        .full  (kbd_full),
        .empty (kbd_empty)
    );

    // RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en && region == REG_RAM) begin
            ram_mem[address[RAM_ADDR_W-1:0]] <= in_data;
        end
    end

    // Screen write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en && region == REG_SCR) begin
            scr_mem[address[SCR_ADDR_W-1:0]] <= in_data;
        end
    end

    // Scanner read port; a same-cycle CPU write to the word returns the old value.
    always_ff @(posedge clk) begin
        if (!reset) begin
            scr_data <= '0;
        end else begin
            scr_data <= scr_mem[scr_addr];
        end
    end

    // Zero-wait-state CPU read mux.
    always_comb begin
        out_data = '0;
        case (region)
            REG_RAM:  out_data = ram_mem[address[RAM_ADDR_W-1:0]];
            REG_SCR:  out_data = scr_mem[address[SCR_ADDR_W-1:0]];
            REG_KBD:  out_data = kbd_empty ? '0 : kbd_head;
            default:  out_data = '0;
        endcase
    end

endmodule

// File: tb/tb_hack_memory.sv
// Self-checking bench for hack_memory: table of write/read vectors, a key-code
// queue model of the keyboard FIFO, and a queue of expected scanner words.
module tb_hack_memory;

    logic        clk;
    logic        reset;
    logic [14:0] address;
    logic [15:0] in_data;
    logic        load;
    logic [15:0] out_data;
    logic        kbd_valid;
    logic [15:0] kbd_code;
    logic        kbd_ready;
    logic [12:0] scr_addr;
    logic [15:0] scr_data;

    int n_vec;
    int n_err;

    logic [15:0] key_q [$];
    logic [15:0] scr_q [$];

    typedef struct {
        logic [14:0] waddr;
        logic [15:0] wdata;
        logic [14:0] raddr;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [9];

    hack_memory #(.KBD_DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .in_data   (in_data),
        .load      (load),
        .out_data  (out_data),
        .kbd_valid (kbd_valid),
        .kbd_code  (kbd_code),
        .kbd_ready (kbd_ready),
        .scr_addr  (scr_addr),
        .scr_data  (scr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: checks ready against the model, then advances the model at the edge.
    task automatic step();
        logic exp_ready;
        logic push_ok;
        logic pop_ok;
        #1;
        exp_ready = reset && (key_q.size() < 4);
        chk("kbd_ready", {15'd0, kbd_ready}, {15'd0, exp_ready});
        push_ok = kbd_valid && exp_ready;
        pop_ok  = reset && load && (address == 15'h6000) && (key_q.size() > 0);
        @(posedge clk);
        if (!reset) begin
            key_q.delete();
        end else begin
            if (pop_ok) void'(key_q.pop_front());
            if (push_ok) key_q.push_back(kbd_code);
        end
        #1;
    endtask

    task automatic chk_kbd(input string name);
        logic [15:0] e;
        address = 15'h6000;
        load    = 1'b0;
        #1;
        e = (key_q.size() > 0) ? key_q[0] : 16'h0000;
        chk(name, out_data, e);
    endtask

    task automatic chk_scr(input string name);
        logic [15:0] e;
        if (scr_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: got empty scoreboard expected entry", name);
        end else begin
            e = scr_q.pop_front();
            chk(name, scr_data, e);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        vecs[0] = '{15'h0005, 16'h1234, 15'h0005, 16'h1234};
        vecs[1] = '{15'h3FFF, 16'hBEEF, 15'h3FFF, 16'hBEEF};
        vecs[2] = '{15'h4000, 16'hFFFF, 15'h4000, 16'hFFFF};
        vecs[3] = '{15'h5FFF, 16'h0A5A, 15'h5FFF, 16'h0A5A};
        vecs[4] = '{15'h7000, 16'h1111, 15'h7000, 16'h0000};
        vecs[5] = '{15'h6001, 16'h2222, 15'h6001, 16'h0000};
        vecs[6] = '{15'h0000, 16'h0001, 15'h0000, 16'h0001};
        vecs[7] = '{15'h7FFF, 16'h3333, 15'h5FFF, 16'h0A5A};
        vecs[8] = '{15'h2000, 16'h5555, 15'h2000, 16'h5555};

        reset = 1'b0; address = '0; in_data = '0; load = 1'b0;
        kbd_valid = 1'b0; kbd_code = '0; scr_addr = '0;
        step();
        step();
        chk("rst_scr_data", scr_data, 16'h0000);
        reset = 1'b1;
        step();
        chk_kbd("kbd_empty_after_rst");

        // Write then read vectors across RAM, screen and unmapped space.
        foreach (vecs[i]) begin
            address = vecs[i].waddr;
            in_data = vecs[i].wdata;
            load    = 1'b1;
            step();
            load    = 1'b0;
            address = vecs[i].raddr;
            #1;
            chk($sformatf("rdwr[%0d]", i), out_data, vecs[i].exp);
        end

        // Scanner: registered read of word 0 and word 0x1FFF.
        scr_addr = 13'd0;
        scr_q.push_back(16'hFFFF);
        step();
        chk_scr("scr_word0");
        scr_addr = 13'h1FFF;
        scr_q.push_back(16'h0A5A);
        step();
        chk_scr("scr_word1fff");

        // Same-cycle CPU write and scanner read of 0x4001 returns the old word.
        address = 15'h4001; in_data = 16'h00AA; load = 1'b1;
        step();
        in_data = 16'h5500; scr_addr = 13'd1;
        scr_q.push_back(16'h00AA);
        step();
        load = 1'b0;
        chk_scr("scr_collide_old");
        scr_q.push_back(16'h5500);
        step();
        chk_scr("scr_collide_new");

        // Fill the FIFO with four codes.
        kbd_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            kbd_code = 16'h0041 + 16'(k);
            step();
        end
        kbd_valid = 1'b0;
        #1;
        chk("kbd_ready_full", {15'd0, kbd_ready}, 16'h0000);
        chk_kbd("kbd_head_41");
        address = 15'h6000; in_data = 16'hDEAD; load = 1'b1;
        step();
        chk_kbd("kbd_head_42");

        // Refill to full, then pop while a key is offered: push must wait a cycle.
        kbd_valid = 1'b1; kbd_code = 16'h0045;
        step();
        kbd_code = 16'h0046;
        address = 15'h6000; load = 1'b1;
        step();
        load = 1'b0;
        step();
        kbd_valid = 1'b0;
        step();
        for (int k = 0; k < 4; k++) begin
            chk_kbd($sformatf("kbd_drain[%0d]", k));
            load = 1'b1;
            step();
        end
        load = 1'b0;
        chk_kbd("kbd_drained");

        // Push and pop together on an empty FIFO.
        kbd_valid = 1'b1; kbd_code = 16'h000D;
        address = 15'h6000; load = 1'b1;
        step();
        kbd_valid = 1'b0; load = 1'b0;
        chk_kbd("kbd_empty_pushpop");
        load = 1'b1;
        step();
        load = 1'b0;

        // Queue three keys, reset mid-operation with an attempted RAM write.
        kbd_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            kbd_code = 16'h0061 + 16'(k);
            step();
        end
        kbd_valid = 1'b0;
        reset = 1'b0;
        address = 15'h0005; in_data = 16'hDEAD; load = 1'b1;
        step();
        chk("rst_scr_clear", scr_data, 16'h0000);
        reset = 1'b1; load = 1'b0;
        chk_kbd("kbd_after_reset");
        chk("kbd_ready_after_rst", {15'd0, kbd_ready}, 16'h0001);
        address = 15'h0005;
        #1;
        chk("ram_kept", out_data, 16'h1234);
        scr_addr = 13'd1;
        scr_q.push_back(16'h5500);
        step();
        chk_scr("scr_kept");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hack_memory.md
HACK_MEMORY -- requirements
Module: hack_memory

Interface
REQ-001 Parameter KBD_DEPTH, default 4, SHALL set the keyboard FIFO depth in entries (power of two, >=2).
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  SHALL be a synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 address  input  15  CPU data address (CPU addressM).
REQ-005 in_data  input  16  CPU write data (CPU outM).
REQ-006 load  input  1  CPU write strobe (CPU writeM).
REQ-007 out_data  output  16  CPU read data (CPU inM).
REQ-008 kbd_valid  input  1  keyboard source has a key code.
REQ-009 kbd_code  input  16  key code; held stable while kbd_valid=1 and kbd_ready=0.
REQ-010 kbd_ready  output  1  block accepts kbd_code this cycle.
REQ-011 scr_addr  input  13  display scanner word address within screen region.
REQ-012 scr_data  output  16  screen word for scr_addr.

Function
REQ-013 Address map SHALL be: 0x0000-0x3FFF RAM (16K words); 0x4000-0x5FFF screen (8K words); 0x6000 KBD register; 0x6001-0x7FFF unmapped.
REQ-014 out_data SHALL be combinational from address, same cycle, with zero wait states, because the CPU consumes inM within a single cycle.
REQ-015 RAM and screen writes SHALL occur on the rising edge when load=1 and address is in range; the new value SHALL be visible on out_data the following cycle.
REQ-016 Unmapped addresses SHALL read 0x0000, and writes to them SHALL be ignored.
REQ-017 A read of 0x6000 SHALL return the FIFO head, or 0x0000 when the FIFO is empty.
REQ-018 A write (load=1) to 0x6000 SHALL pop the FIFO head and discard in_data; a pop on an empty FIFO SHALL be ignored.
REQ-019 A push SHALL occur on an edge with kbd_valid=1 and kbd_ready=1.
REQ-020 kbd_ready SHALL equal (FIFO not full) AND reset deasserted; it SHALL be 0 whenever the FIFO is full, even in a popping cycle.
REQ-021 A simultaneous push and pop on a non-empty FIFO SHALL leave the count unchanged; the popped entry SHALL be the old head.
REQ-022 Simultaneous push and pop on an empty FIFO: the pop SHALL be ignored and the push SHALL complete, giving count 1.
REQ-023 FIFO read/write pointers SHALL wrap modulo KBD_DEPTH; the count SHALL be log2(KBD_DEPTH)+1 bits wide.
REQ-024 scr_data SHALL be registered with 1-cycle latency from scr_addr.
REQ-025 When a CPU screen write and a scanner read hit the same word in one cycle, scr_data SHALL return the old word.

Reset
REQ-026 While reset=0 at an edge: FIFO count, read pointer and write pointer SHALL clear to 0, and scr_data SHALL clear to 0x0000.
REQ-027 While reset=0, kbd_ready SHALL be 0 and CPU writes SHALL be ignored.
REQ-028 RAM and screen contents SHALL NOT be cleared by reset.
REQ-029 A reset asserted mid-operation SHALL discard all queued keys; after release, a read of 0x6000 SHALL return 0x0000.

Structure
REQ-030 Address-map constants SHALL live in the shared package hack_pkg, alongside word and address width constants: RAM_BASE, SCR_BASE, KBD_ADDR, RAM_WORDS, SCR_WORDS.
REQ-031 The keyboard FIFO SHALL be the single sub-module key_fifo, with ports push, pop, din, dout, full, empty and parameter DEPTH.
REQ-032 RAM and screen SHALL be behavioural arrays: asynchronous read port for the CPU, synchronous read port for the scanner.

Verification
REQ-033 Write 0x1234 to 0x0005, then read 0x0005 -> out_data=0x1234 on the next cycle; a read of 0x7000 -> 0x0000.
REQ-034 Write 0xFFFF to 0x4000, then drive scr_addr=0 -> scr_data=0xFFFF one cycle later; same-cycle write and read of 0x4001 -> old value.
REQ-035 Push codes 0x41, 0x42, 0x43, 0x44 -> kbd_ready=0 after the 4th push; reads of 0x6000 return 0x41; after a pop they return 0x42.
REQ-036 FIFO full with kbd_valid=1 while popping -> no push occurs and count goes 4 to 3; the next cycle the push is accepted and count returns to 4.
REQ-037 FIFO empty, push 0x0D and pop in the same cycle -> next read of 0x6000 = 0x000D.
REQ-038 Push 3 keys, then hold reset=0 for 1 cycle -> read of 0x6000 = 0x0000, kbd_ready=1 after release, and RAM data is preserved.
